// File: rtl/vga_pkg.sv
// vga_pkg: pattern modes, timing presets and width helper shared by the video timing block.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    localparam int VGA_H_VISIBLE  = 640;
    localparam int VGA_H_FRONT    = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BACK     = 48;
    localparam int VGA_V_VISIBLE  = 480;
    localparam int VGA_V_FRONT    = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BACK     = 33;

    localparam int SVGA_H_VISIBLE = 800;
    localparam int SVGA_H_FRONT   = 40;
    localparam int SVGA_H_SYNC    = 128;
    localparam int SVGA_H_BACK    = 88;
    localparam int SVGA_V_VISIBLE = 600;
    localparam int SVGA_V_FRONT   = 1;
    localparam int SVGA_V_SYNC    = 4;
    localparam int SVGA_V_BACK    = 23;

    // Never returns 0 so a one-value counter still gets a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: control inputs and video outputs of the timing generator.
interface vga_timing_gen_if #(
    parameter int X_W     = 11,
    parameter int Y_W     = 10,
    parameter int FC_W    = 6,
    parameter int COLOR_W = 8
);
    logic               ENABLE;
    logic [1:0]         MODE;
    logic               SYNC;
    logic               SYNC_EN;
    logic [X_W-1:0]     VGA_X;
    logic [Y_W-1:0]     VGA_Y;
    logic               VGA_HS;
    logic               VGA_VS;
    logic               VGA_VISIBLE;
    logic [COLOR_W-1:0] VGA_RED;
    logic [COLOR_W-1:0] VGA_GREEN;
    logic [COLOR_W-1:0] VGA_BLUE;
    logic               FRAME_START;
    logic [FC_W-1:0]    FRAME_COUNT;
    logic               HEARTBEAT;

    modport master (
        input  ENABLE, MODE, SYNC, SYNC_EN,
        output VGA_X, VGA_Y, VGA_HS, VGA_VS, VGA_VISIBLE,
               VGA_RED, VGA_GREEN, VGA_BLUE, FRAME_START, FRAME_COUNT, HEARTBEAT
    );

    modport slave (
        output ENABLE, MODE, SYNC, SYNC_EN,
        input  VGA_X, VGA_Y, VGA_HS, VGA_VS, VGA_VISIBLE,
               VGA_RED, VGA_GREEN, VGA_BLUE, FRAME_START, FRAME_COUNT, HEARTBEAT
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: combinational test-pattern colour for one pixel position.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 800,
    parameter int V_VISIBLE = 600,
    parameter int X_W       = 11,
    parameter int Y_W       = 10,
    parameter int FC_W      = 6,
    parameter int COLOR_W   = 8
) (
    input  logic [X_W-1:0]     hc,
    input  logic [Y_W-1:0]     vc,
    input  mode_t              mode,
    input  logic [FC_W-1:0]    fc,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);
    logic [2:0] bar;
    logic       grid;

    always_comb begin
        // Bar index floor(hc*8/H_VISIBLE) as a count of crossed constant thresholds.
        bar = '0;
        for (int k = 1; k < 8; k++)
            bar = bar + 3'(hc >= X_W'((k * H_VISIBLE + 7) / 8));
        grid = hc == '0 || hc == X_W'(H_VISIBLE - 1) || vc == '0 || vc == Y_W'(V_VISIBLE - 1) ||
               6'(hc) == 6'd0 || 6'(vc) == 6'd0;
        red   = mode == MODE_BARS ? {COLOR_W{~bar[2]}} :
                mode == MODE_GRID ? {COLOR_W{grid}} :
                mode == MODE_GRAD ? COLOR_W'(hc) : '0;
        green = mode == MODE_BARS ? {COLOR_W{~bar[1]}} :
                mode == MODE_GRID ? {COLOR_W{grid}} :
                mode == MODE_GRAD ? COLOR_W'(vc) : '0;
        blue  = mode == MODE_BARS ? {COLOR_W{~bar[0]}} :
                mode == MODE_GRID ? {COLOR_W{grid}} :
                mode == MODE_GRAD ? COLOR_W'(fc) : '0;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing, frame lock, frame counter and test patterns.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE       = SVGA_H_VISIBLE,
    parameter int H_FRONT         = SVGA_H_FRONT,
    parameter int H_SYNC          = SVGA_H_SYNC,
    parameter int H_BACK          = SVGA_H_BACK,
    parameter int V_VISIBLE       = SVGA_V_VISIBLE,
    parameter int V_FRONT         = SVGA_V_FRONT,
    parameter int V_SYNC          = SVGA_V_SYNC,
    parameter int V_BACK          = SVGA_V_BACK,
    parameter bit HS_POL          = 1'b1,
    parameter bit VS_POL          = 1'b1,
    parameter int FRAMES_PER_TICK = 60,
    parameter int COLOR_W         = 8
) (
    input logic               VIDEO_CLK,
    input logic               RESET,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int X_W      = clog2(H_TOTAL);
    localparam int Y_W      = clog2(V_TOTAL);
    localparam int FC_W     = clog2(FRAMES_PER_TICK);
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [X_W-1:0]     hc;
    logic [Y_W-1:0]     vc;
    logic               sync_q, sync_p;
    mode_t              mode_q, mode_eff;
    logic               h_end, v_end, rise, fs, fc_wrap, vis, hs_act, vs_act;
    logic [FC_W-1:0]    fc_nxt;
    logic [COLOR_W-1:0] red, green, blue;

    always_comb begin
        h_end    = hc == X_W'(H_TOTAL - 1);
        v_end    = vc == Y_W'(V_TOTAL - 1);
        rise     = bus.SYNC_EN && sync_q && !sync_p;
        fs       = bus.ENABLE && hc == '0 && vc == '0;
        fc_wrap  = bus.FRAME_COUNT == FC_W'(FRAMES_PER_TICK - 1);
        // The frame-start pixel already shows the new count and mode, matching the registered outputs.
        fc_nxt   = !fs ? bus.FRAME_COUNT : fc_wrap ? '0 : bus.FRAME_COUNT + FC_W'(1);
        mode_eff = fs ? mode_t'(bus.MODE) : mode_q;
        vis      = bus.ENABLE && int'(hc) < H_VISIBLE && int'(vc) < V_VISIBLE;
        hs_act   = bus.ENABLE && int'(hc) >= HS_START && int'(hc) < HS_END;
        vs_act   = bus.ENABLE && int'(vc) >= VS_START && int'(vc) < VS_END;
    end

    vga_pattern_gen #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .FC_W      (FC_W),
        .COLOR_W   (COLOR_W)
    ) u_pattern (
        .hc    (hc),
        .vc    (vc),
        .mode  (mode_eff),
        .fc    (fc_nxt),
        .red   (red),
        .green (green),
        .blue  (blue)
    );

    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            hc              <= '0;
            vc              <= '0;
            sync_q          <= 1'b0;
            sync_p          <= 1'b0;
            mode_q          <= MODE_BLACK;
            bus.VGA_X       <= '0;
            bus.VGA_Y       <= '0;
            bus.VGA_HS      <= !HS_POL;
            bus.VGA_VS      <= !VS_POL;
            bus.VGA_VISIBLE <= 1'b0;
            bus.VGA_RED     <= '0;
            bus.VGA_GREEN   <= '0;
            bus.VGA_BLUE    <= '0;
            bus.FRAME_START <= 1'b0;
            bus.FRAME_COUNT <= '0;
            bus.HEARTBEAT   <= 1'b0;
        end else begin
            sync_q <= bus.SYNC;
            sync_p <= sync_q;
            // A lock edge landing on a natural wrap gives the same (0,0), so no frame is counted twice.
            if (bus.ENABLE) begin
                hc <= (rise || h_end) ? '0 : hc + X_W'(1);
                vc <= rise ? '0 : !h_end ? vc : v_end ? '0 : vc + Y_W'(1);
            end
            mode_q          <= mode_eff;
            bus.VGA_X       <= hc;
            bus.VGA_Y       <= vc;
            bus.VGA_HS      <= hs_act ? HS_POL : !HS_POL;
            bus.VGA_VS      <= vs_act ? VS_POL : !VS_POL;
            bus.VGA_VISIBLE <= vis;
            bus.VGA_RED     <= vis ? red : '0;
            bus.VGA_GREEN   <= vis ? green : '0;
            bus.VGA_BLUE    <= vis ? blue : '0;
            bus.FRAME_START <= fs;
            bus.FRAME_COUNT <= fc_nxt;
            bus.HEARTBEAT   <= bus.HEARTBEAT ^ (fs && fc_wrap);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors and corner sequences on a 16x8 timing with 3 frames per tick.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    int   fs_seen = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W(4), .Y_W(3), .FC_W(2), .COLOR_W(8)) bus ();

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (4),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (2),
        .HS_POL (1'b0), .VS_POL (1'b1), .FRAMES_PER_TICK (3), .COLOR_W (8)
    ) dut (
        .VIDEO_CLK (clk),
        .RESET     (rst),
        .bus       (bus)
    );

    typedef struct {
        logic [1:0]  mode;
        int          x;
        int          y;
        logic        hs;
        logic        vs;
        logic        vis;
        logic        bfc;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.FRAME_START) fs_seen++;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin step(); n++; end while (!bus.FRAME_START && n < 300);
        chk("wait_frame_start", 32'(bus.FRAME_START), 1);
    endtask

    task automatic wait_xy(input int x, input int y);
        int n = 0;
        do begin step(); n++; end
        while (!(int'(bus.VGA_X) == x && int'(bus.VGA_Y) == y) && n < 400);
        chk($sformatf("wait_xy_%0d_%0d", x, y), 32'(int'(bus.VGA_X) == x && int'(bus.VGA_Y) == y), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"}, 32'(bus.VGA_X), 0);
        chk({tag, "_y"}, 32'(bus.VGA_Y), 0);
        chk({tag, "_hs"}, 32'(bus.VGA_HS), 1);
        chk({tag, "_vs"}, 32'(bus.VGA_VS), 0);
        chk({tag, "_vis"}, 32'(bus.VGA_VISIBLE), 0);
        chk({tag, "_rgb"}, {8'h0, bus.VGA_RED, bus.VGA_GREEN, bus.VGA_BLUE}, 0);
        chk({tag, "_fs"}, 32'(bus.FRAME_START), 0);
        chk({tag, "_fc"}, 32'(bus.FRAME_COUNT), 0);
        chk({tag, "_hb"}, 32'(bus.HEARTBEAT), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vis_n, hs_low, vs_high, hs_err, vs_err, max_x, max_y, fs_n, dbl, base;
        logic prev;
        logic [26:0] exp_v;
        tbl[0]  = '{2'd1, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFF00FF};
        tbl[1]  = '{2'd1, 3, 1, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFF0000};
        tbl[2]  = '{2'd1, 6, 2, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0000FF};
        tbl[3]  = '{2'd1, 7, 3, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        tbl[4]  = '{2'd1, 12, 1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[5]  = '{2'd1, 10, 5, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000};
        tbl[6]  = '{2'd2, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF};
        tbl[7]  = '{2'd2, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF};
        tbl[8]  = '{2'd2, 3, 1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        tbl[9]  = '{2'd2, 7, 2, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF};
        tbl[10] = '{2'd2, 3, 2, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        tbl[11] = '{2'd2, 4, 3, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFFFFF};
        tbl[12] = '{2'd2, 9, 0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[13] = '{2'd0, 2, 1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000};
        tbl[14] = '{2'd0, 11, 6, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        tbl[15] = '{2'd3, 5, 2, 1'b1, 1'b0, 1'b1, 1'b1, 24'h050200};
        tbl[16] = '{2'd3, 7, 3, 1'b1, 1'b0, 1'b1, 1'b1, 24'h070300};
        tbl[17] = '{2'd3, 8, 3, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};

        rst = 1'b1;
        bus.ENABLE = 1'b1;
        bus.MODE = 2'd1;
        bus.SYNC = 1'b0;
        bus.SYNC_EN = 1'b0;
        repeat (2) step();
        chk_reset_state("reset");
        rst = 1'b0;
        step();
        chk("first_x", 32'(bus.VGA_X), 0);
        chk("first_y", 32'(bus.VGA_Y), 0);
        chk("first_fs", 32'(bus.FRAME_START), 1);
        chk("first_fc", 32'(bus.FRAME_COUNT), 1);
        chk("first_rgb", {8'h0, bus.VGA_RED, bus.VGA_GREEN, bus.VGA_BLUE}, 32'h00FFFFFF);

        // Two full frames of geometry starting at the first pixel.
        vis_n = 0; hs_low = 0; vs_high = 0; hs_err = 0; vs_err = 0; max_x = 0; max_y = 0; fs_n = 0;
        for (int i = 0; i < 256; i++) begin
            vis_n += int'(bus.VGA_VISIBLE);
            hs_low += int'(!bus.VGA_HS);
            vs_high += int'(bus.VGA_VS);
            hs_err += int'(!bus.VGA_HS != (bus.VGA_X == 4'd10 || bus.VGA_X == 4'd11));
            vs_err += int'(bus.VGA_VS != (bus.VGA_Y == 3'd5));
            fs_n += int'(bus.FRAME_START);
            if (int'(bus.VGA_X) > max_x) max_x = int'(bus.VGA_X);
            if (int'(bus.VGA_Y) > max_y) max_y = int'(bus.VGA_Y);
            step();
        end
        chk("h_total", 32'(max_x + 1), 16);
        chk("v_total", 32'(max_y + 1), 8);
        chk("visible_count", 32'(vis_n), 64);
        chk("hs_low_count", 32'(hs_low), 32);
        chk("vs_high_count", 32'(vs_high), 32);
        chk("hs_position_errors", 32'(hs_err), 0);
        chk("vs_position_errors", 32'(vs_err), 0);
        chk("frame_starts_2f", 32'(fs_n), 2);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].mode != bus.MODE) begin
                bus.MODE = tbl[i].mode;
                wait_fs();
            end
            wait_xy(tbl[i].x, tbl[i].y);
            exp_v = {tbl[i].hs, tbl[i].vs, tbl[i].vis,
                     tbl[i].bfc ? {tbl[i].rgb[23:8], 8'(fs_seen % 3)} : tbl[i].rgb};
            chk($sformatf("vec%0d", i),
                32'({bus.VGA_HS, bus.VGA_VS, bus.VGA_VISIBLE, bus.VGA_RED, bus.VGA_GREEN, bus.VGA_BLUE}),
                32'(exp_v));
        end

        // Lock edge at pixel (5,2) restarts the frame three clocks later.
        bus.SYNC_EN = 1'b1;
        wait_xy(5, 2);
        bus.SYNC = 1'b1;
        step();
        chk("lock_x_p1", 32'(bus.VGA_X), 6);
        step();
        chk("lock_x_p2", 32'(bus.VGA_X), 7);
        chk("lock_fs_p2", 32'(bus.FRAME_START), 0);
        step();
        chk("lock_xy_p3", 32'({bus.VGA_X, bus.VGA_Y}), 0);
        chk("lock_fs_p3", 32'(bus.FRAME_START), 1);
        chk("lock_fc", 32'(bus.FRAME_COUNT), 32'(fs_seen % 3));
        bus.SYNC = 1'b0;

        bus.SYNC_EN = 1'b0;
        wait_xy(5, 2);
        bus.SYNC = 1'b1;
        repeat (3) step();
        chk("nolock_x", 32'(bus.VGA_X), 8);
        chk("nolock_y", 32'(bus.VGA_Y), 2);
        chk("nolock_fs", 32'(bus.FRAME_START), 0);
        bus.SYNC = 1'b0;

        // Lock edge that coincides with the natural wrap from (15,7).
        bus.SYNC_EN = 1'b1;
        wait_xy(13, 7);
        bus.SYNC = 1'b1;
        base = fs_seen;
        repeat (3) step();
        chk("wrap_lock_fs", 32'(bus.FRAME_START), 1);
        chk("wrap_lock_xy", 32'({bus.VGA_X, bus.VGA_Y}), 0);
        repeat (7) step();
        chk("wrap_lock_fs_count", 32'(fs_seen - base), 1);
        chk("wrap_lock_fc", 32'(bus.FRAME_COUNT), 32'(fs_seen % 3));
        bus.SYNC = 1'b0;
        bus.SYNC_EN = 1'b0;

        // Mode change mid-frame only applies from the next frame.
        bus.MODE = 2'd1;
        wait_fs();
        wait_xy(2, 1);
        bus.MODE = 2'd3;
        wait_xy(4, 2);
        chk("midframe_bars", {8'h0, bus.VGA_RED, bus.VGA_GREEN, bus.VGA_BLUE}, 32'h0000FFFF);
        wait_fs();
        wait_xy(3, 2);
        chk("nextframe_grad", {8'h0, bus.VGA_RED, bus.VGA_GREEN, bus.VGA_BLUE},
            {8'h0, 8'd3, 8'd2, 8'(fs_seen % 3)});

        // Asynchronous reset mid-line, then a disabled stretch.
        wait_xy(6, 1);
        #1;
        rst = 1'b1;
        bus.ENABLE = 1'b0;
        #1;
        chk_reset_state("async_reset");
        fs_seen = 0;
        step();
        rst = 1'b0;
        repeat (20) step();
        chk_reset_state("disabled");
        bus.ENABLE = 1'b1;
        step();
        chk("resume_xy", 32'({bus.VGA_X, bus.VGA_Y}), 0);
        chk("resume_fs", 32'(bus.FRAME_START), 1);
        chk("resume_fc", 32'(bus.FRAME_COUNT), 1);

        dbl = 0;
        prev = bus.FRAME_START;
        for (int i = 0; i < 800; i++) begin
            step();
            if (bus.FRAME_START) begin
                chk($sformatf("fc_frame%0d", fs_seen), 32'(bus.FRAME_COUNT), 32'(fs_seen % 3));
                chk($sformatf("hb_frame%0d", fs_seen), 32'(bus.HEARTBEAT), 32'((fs_seen / 3) % 2));
                if (prev) dbl++;
            end
            prev = bus.FRAME_START;
        end
        chk("fs_count_7f", 32'(fs_seen), 7);
        chk("fs_one_cycle", 32'(dbl), 0);
        chk("hb_after_7f", 32'(bus.HEARTBEAT), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
